id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32I core. It sits directly downstream of the instruction decoder/control unit.
- Captures the 11-bit control bundle plus decoded operands each cycle and presents them to the EX stage.
- Contains the load-use hazard detector. It inserts bubbles on load-use hazards and on branch/jump flush, and freezes on downstream hold.

Parameters:
- XLEN, 32, datapath width of PC, register operands and immediate.
- CTRL_W, 11, control bundle width. Bit order MSB→LSB: isBranch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, Jump, WBSrc[1:0].
- CNT_W, 32, bubble counter width (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_ctrl  in  CTRL_W  control bundle from decoder
- id_pc  in  XLEN  instruction PC
- id_rs1_data  in  XLEN  register-file read 1
- id_rs2_data  in  XLEN  register-file read 2
- id_imm  in  XLEN  generated immediate
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rd  in  5  destination register index
- id_funct  in  4  {funct7[5], funct3}
- flush  in  1  branch/jump redirect from EX/MEM
- ex_hold  in  1  downstream stall (e.g. multi-cycle memory)
- hazard_stall  out  1  combinational load-use stall to PC and IF/ID
- ex_valid  out  1  registered valid
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered data
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices (rs1/rs2 feed the forwarding unit)
- ex_funct  out  4  registered funct bits
- bubble_cnt  out  CNT_W  bubble counter (optional feature)

Behaviour:
- Reset: when rst_n=0 at a clk edge, all ex_* outputs = 0 and ex_valid = 0. Reset mid-stall or mid-hold discards the held contents. Reset dominates all other inputs.
- Hazard detect (combinational):
  - hazard_stall = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd≠0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - Forced to 0 while flush=1 or ex_hold=1. Under ex_hold the register freezes anyway; under flush the ID instruction is squashed.
- Register update per clk edge, priority order:
  1. reset
  2. flush=1 → load bubble
  3. ex_hold=1 → keep all ex_* unchanged
  4. hazard_stall=1 → load bubble
  5. otherwise load all id_* fields into ex_*. ex_valid = id_valid.
- Bubble: ex_valid=0, ex_ctrl=0, all data and index fields = 0.
- id_valid=0 with a normal load: fields are captured as presented. ex_ctrl is forced to 0 so no RegWrite, MemWrite or branch escapes.
- Latency: exactly 1 cycle from ID capture to EX presentation. The stage never buffers more than one instruction.
- Load-use stall lasts exactly one cycle. After the bubble, ex_ctrl.MemRead=0, so hazard_stall drops and the held ID instruction loads on the next edge.
- x0 destination never causes a stall.
- A back-to-back load followed by a dependent load stalls once per dependency.
- Simultaneous flush and hazard_stall: flush wins, hazard_stall output = 0.
- Simultaneous flush and ex_hold: flush wins. The bubble is loaded even though EX is held, because the EX instruction is squashed by the redirect.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on every clk edge where a bubble is loaded by rule 2 or rule 4, and ex_hold is not the selected action.
  - Saturates at all-ones. Cleared by reset.
- Undefined: bubble_cnt is constant 0 and no counter flops are inferred.

Test Plan:
- Reset then normal flow: hold rst_n=0 for 2 cycles → all outputs 0. Release, drive id_valid=1, id_pc=0x100, id_ctrl=11'b00010001000 (R-type) → next cycle ex_pc=0x100, ex_ctrl=11'b00010001000, ex_valid=1.
- Load-use: EX holds a load (MemRead=1, ex_rd=5) while ID has id_rs1=5 → hazard_stall=1. Next cycle ex_valid=0, ex_ctrl=0, hazard_stall=0. The following cycle the ID instruction appears in EX. bubble_cnt=1 with the macro defined.
- x0 load: load with ex_rd=0, ID id_rs2=0 → hazard_stall=0 and no bubble.
- Flush priority: flush=1 in the same cycle as a load-use condition and ex_hold=1 → hazard_stall=0. Next cycle ex_valid=0 and ex_ctrl=0.
- Hold: ex_hold=1 for 3 cycles with changing id_* → ex_* unchanged all 3 cycles. On release, the current id_* loads.
- Reset mid-hold: ex_hold=1 with valid EX contents, rst_n=0 for 1 edge → all ex_* = 0, ex_valid=0, bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage
// RV32I core.
//
// Each clk edge it captures the decoder's control bundle and operands and
// presents them to EX one cycle later. The update priority is: reset, then
// flush (bubble), then ex_hold (freeze), then load-use stall (bubble), then
// a normal load.
//
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   id_valid, id_ctrl      ID valid flag and 11-bit control bundle
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm    datapath operands
//   id_rs1/rs2/rd, id_funct register indices and {funct7[5], funct3}
//   flush                  branch/jump redirect from EX/MEM
//   ex_hold                downstream stall; the register freezes
//   hazard_stall           combinational load-use stall to PC and IF/ID
//   ex_*                   registered copies presented to EX
//   bubble_cnt             saturating count of inserted bubbles
//
// Optional feature: define ID_EX_BUBBLE_CNT_EN to build the bubble counter.
// Without it, bubble_cnt is tied to 0.
//
// ctrl bit order (MSB..LSB): isBranch, MemRead, MemtoReg, ALUOp[1:0],
// MemWrite, ALUSrc, RegWrite, Jump, WBSrc[1:0].
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_funct,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // MemRead sits just below isBranch.
  localparam int MEMREAD_BIT = CTRL_W - 2;

  logic ld_use;
  logic bubble_ld;

  // A load in EX whose rd feeds the ID instruction needs one bubble. x0 never
  // carries a real value, so it is excluded.
  assign ld_use = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Flush squashes the ID instruction, so no stall is needed. Under a hold
  // the register freezes anyway, so no stall is needed there either.
  assign hazard_stall = ld_use & ~flush & ~ex_hold;

  // Bubble load: flush wins over hold; the stall is already masked by hold.
  assign bubble_ld = flush | hazard_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble_ld) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (!ex_hold) begin
      ex_valid    <= id_valid;
      // An invalid slot must not carry side-effecting control.
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bubble_ld && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed test of id_ex_stage_reg. It covers reset, normal flow, load-use
// stalls (rs1, back-to-back, x0), flush priority, hold, invalid-slot capture,
// and reset during a hold.
module tb_id_ex_stage_reg;
  localparam int XLEN = 32, CTRL_W = 11, CNT_W = 32;
  localparam logic [10:0] C_R  = 11'b00010001000;
  localparam logic [10:0] C_LD = 11'b01100011000;

  logic              clk = 1'b0, rst_n;
  logic              id_valid, flush, ex_hold, hazard_stall, ex_valid;
  logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
  logic [3:0]        id_funct, ex_funct;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_cmp = 0, n_err = 0;
  int bub = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct(id_funct), .flush(flush), .ex_hold(ex_hold),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bub(input string tag);
    int e;
`ifdef ID_EX_BUBBLE_CNT_EN
    e = bub;
`else
    e = 0;
`endif
    chk(tag, 64'(bubble_cnt), 64'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] c, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = pc ^ 32'hA5A5_0000; id_rs2_data = pc ^ 32'h5A5A_0000;
    id_imm = pc + 32'd16; id_funct = pc[5:2];
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    drive(1'b1, C_R, 32'h0DEAD, 5'd1, 5'd2, 5'd3);
    tick(); tick();
    chk("rst_valid", 64'(ex_valid), 0);
    chk("rst_ctrl", 64'(ex_ctrl), 0);
    chk("rst_pc", 64'(ex_pc), 0);
    chk("rst_rd", 64'(ex_rd), 0);
    chk_bub("rst_bub");

    // normal flow
    rst_n = 1'b1;
    drive(1'b1, C_R, 32'h100, 5'd1, 5'd2, 5'd3);
    tick();
    chk("nrm_pc", 64'(ex_pc), 64'h100);
    chk("nrm_ctrl", 64'(ex_ctrl), 64'(C_R));
    chk("nrm_valid", 64'(ex_valid), 1);
    chk("nrm_rs1d", 64'(ex_rs1_data), 64'(32'h100 ^ 32'hA5A5_0000));
    chk("nrm_imm", 64'(ex_imm), 64'h110);
    chk("nrm_rd", 64'(ex_rd), 3);

    // load-use on rs1
    drive(1'b1, C_LD, 32'h104, 5'd1, 5'd2, 5'd5);
    tick();
    chk("ld_ctrl", 64'(ex_ctrl), 64'(C_LD));
    drive(1'b1, C_R, 32'h108, 5'd5, 5'd7, 5'd6);
    chk("lu_stall", 64'(hazard_stall), 1);
    tick(); bub++;
    chk("lu_bvalid", 64'(ex_valid), 0);
    chk("lu_bctrl", 64'(ex_ctrl), 0);
    chk("lu_bpc", 64'(ex_pc), 0);
    chk("lu_stall_drop", 64'(hazard_stall), 0);
    chk_bub("lu_bub");
    tick();
    chk("lu_pc", 64'(ex_pc), 64'h108);
    chk("lu_valid", 64'(ex_valid), 1);

    // x0 load destination: no stall
    drive(1'b1, C_LD, 32'h10C, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, C_R, 32'h110, 5'd3, 5'd0, 5'd4);
    chk("x0_stall", 64'(hazard_stall), 0);
    tick();
    chk("x0_pc", 64'(ex_pc), 64'h110);

    // back-to-back dependent loads: one stall per dependency
    drive(1'b1, C_LD, 32'h114, 5'd1, 5'd2, 5'd5);
    tick();
    drive(1'b1, C_LD, 32'h118, 5'd5, 5'd0, 5'd8);
    chk("b2b_stall1", 64'(hazard_stall), 1);
    tick(); bub++;
    chk("b2b_bub1", 64'(ex_valid), 0);
    tick();
    chk("b2b_pc1", 64'(ex_pc), 64'h118);
    drive(1'b1, C_R, 32'h11C, 5'd9, 5'd8, 5'd10);
    chk("b2b_stall2", 64'(hazard_stall), 1);
    tick(); bub++;
    chk("b2b_bub2", 64'(ex_ctrl), 0);
    chk("b2b_stall_drop", 64'(hazard_stall), 0);
    tick();
    chk("b2b_pc2", 64'(ex_pc), 64'h11C);
    chk_bub("b2b_cnt");

    // flush beats stall and hold
    drive(1'b1, C_LD, 32'h120, 5'd1, 5'd2, 5'd5);
    tick();
    flush = 1'b1; ex_hold = 1'b1;
    drive(1'b1, C_R, 32'h124, 5'd5, 5'd2, 5'd6);
    chk("fl_stall", 64'(hazard_stall), 0);
    tick(); bub++;
    chk("fl_valid", 64'(ex_valid), 0);
    chk("fl_ctrl", 64'(ex_ctrl), 0);
    chk_bub("fl_bub");
    flush = 1'b0; ex_hold = 1'b0;
    tick();
    chk("fl_next", 64'(ex_pc), 64'h124);

    // hold for 3 cycles while ID changes
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, C_LD, 32'h200 + 32'(i * 4), 5'd11, 5'd12, 5'd13);
      tick();
      chk("hold_pc", 64'(ex_pc), 64'h124);
      chk("hold_ctrl", 64'(ex_ctrl), 64'(C_R));
    end
    chk_bub("hold_bub");
    ex_hold = 1'b0;
    #1;
    tick();
    chk("rel_pc", 64'(ex_pc), 64'h208);
    chk("rel_ctrl", 64'(ex_ctrl), 64'(C_LD));

    // invalid slot: fields captured, ctrl zeroed
    drive(1'b0, C_R, 32'h300, 5'd1, 5'd2, 5'd3);
    tick();
    chk("inv_valid", 64'(ex_valid), 0);
    chk("inv_ctrl", 64'(ex_ctrl), 0);
    chk("inv_pc", 64'(ex_pc), 64'h300);

    // hold masks stall, then reset during hold
    drive(1'b1, C_LD, 32'h400, 5'd1, 5'd2, 5'd5);
    tick();
    ex_hold = 1'b1;
    drive(1'b1, C_R, 32'h404, 5'd5, 5'd2, 5'd6);
    chk("hold_stall", 64'(hazard_stall), 0);
    rst_n = 1'b0;
    tick(); bub = 0;
    chk("rh_valid", 64'(ex_valid), 0);
    chk("rh_pc", 64'(ex_pc), 0);
    chk("rh_ctrl", 64'(ex_ctrl), 0);
    chk_bub("rh_bub");
    rst_n = 1'b1; ex_hold = 1'b0;
    tick();
    chk("post_pc", 64'(ex_pc), 64'h404);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
